vospi_packet_parser: RTL

VOSPI_PACKET_PARSER -- requirements
Module: vospi_packet_parser

---
 rtl/vospi_packet_parser.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vospi_packet_parser.sv
// VoSPI packet parser: splits the word stream into ID, CRC and payload,
// checks line sequencing and flags discard packets and frame completion.
module vospi_packet_parser #(
  parameter int PAYLOAD_WORDS_P = 80,
  parameter int LINES_P         = 60
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [15:0] word_i,
  input  logic        word_valid_i,
  input  logic        resync_i,
  output logic [15:0] payload_o,
  output logic        payload_valid_o,
  output logic        sol_o,
  output logic        eol_o,
  output logic [6:0]  line_o,
  output logic [15:0] crc_o,
  output logic        frame_done_o,
  output logic        discard_o,
  output logic        seq_err_o
);

  localparam int CNT_W = (PAYLOAD_WORDS_P > 1) ? $clog2(PAYLOAD_WORDS_P) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAYLOAD_WORDS_P - 1);
  localparam logic [11:0]      LAST_LINE = 12'(LINES_P - 1);

  localparam logic [1:0] HDR_ID  = 2'd0;
  localparam logic [1:0] HDR_CRC = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] SKIP    = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] word_cnt;
  logic [11:0]      expected_line;
  logic [11:0]      pkt_num;
  logic             pkt_discard;
  logic             pkt_accept;

  logic [11:0] id_num;
  logic        id_discard;
  logic        id_accept;
  logic        last_word;

  // Packet 0 is always accepted so the parser can re-lock onto a new frame.
  always_comb begin
    id_num     = word_i[11:0];
    id_discard = (word_i[11:8] == 4'hF);
    id_accept  = !id_discard && ((id_num == expected_line) || (id_num == 12'd0));
    last_word  = (word_cnt == LAST_WORD);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state           <= HDR_ID;
      word_cnt        <= '0;
      expected_line   <= '0;
      pkt_num         <= '0;
      pkt_discard     <= 1'b0;
      pkt_accept      <= 1'b0;
      payload_o       <= '0;
      payload_valid_o <= 1'b0;
      sol_o           <= 1'b0;
      eol_o           <= 1'b0;
      line_o          <= '0;
      crc_o           <= '0;
      frame_done_o    <= 1'b0;
      discard_o       <= 1'b0;
      seq_err_o       <= 1'b0;
    end else begin
      payload_valid_o <= 1'b0;
      sol_o           <= 1'b0;
      eol_o           <= 1'b0;
      frame_done_o    <= 1'b0;
      discard_o       <= 1'b0;
      seq_err_o       <= 1'b0;
      // Resync takes priority over any word arriving in the same cycle.
      if (resync_i) begin
        state         <= HDR_ID;
        word_cnt      <= '0;
        expected_line <= '0;
      end else if (word_valid_i) begin
        case (state)
          HDR_ID: begin
            pkt_num     <= id_num;
            pkt_discard <= id_discard;
            pkt_accept  <= id_accept;
            word_cnt    <= '0;
            if (!id_discard && !id_accept) begin
              seq_err_o     <= 1'b1;
              expected_line <= '0;
            end
            state <= HDR_CRC;
          end
          HDR_CRC: begin
            if (pkt_accept) begin
              crc_o  <= word_i;
              line_o <= pkt_num[6:0];
              state  <= PAYLOAD;
            end else begin
              state <= SKIP;
            end
          end
          PAYLOAD: begin
            payload_o       <= word_i;
            payload_valid_o <= 1'b1;
            sol_o           <= (word_cnt == '0);
            eol_o           <= last_word;
            if (last_word) begin
              state    <= HDR_ID;
              word_cnt <= '0;
              if (pkt_num == LAST_LINE) begin
                expected_line <= '0;
                frame_done_o  <= 1'b1;
              end else begin
                expected_line <= pkt_num + 12'd1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          SKIP: begin
            if (last_word) begin
              state     <= HDR_ID;
              word_cnt  <= '0;
              discard_o <= pkt_discard;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: state <= HDR_ID;
        endcase
      end
    end
  end

endmodule
